// File: rtl/shift_frame_ctrl_pkg.sv
// Shared types for the shift frame controller: FSM state encoding and
// the bit-counter width helper.
package shift_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// Parallel-side handshake bundle: transmit word in, received word out.
interface shift_frame_ctrl_if #(
  parameter int SIZE = 8
);

  logic            tx_valid;
  logic            tx_ready;
  logic [SIZE-1:0] tx_data;
  logic            rx_valid;
  logic [SIZE-1:0] rx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready,
    input  rx_valid,
    input  rx_data
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready,
    output rx_valid,
    output rx_data
  );

endinterface

// File: rtl/shift_frame_ctrl_shift_register.sv
// Parallel-load, left-shifting register; MSB leaves on serOut, serIn enters the LSB.
module shift_register #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic            serIn,
  input  logic [SIZE-1:0] dataIn,
  output logic            serOut,
  output logic [SIZE-1:0] dataOut
);

  logic [SIZE-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= dataIn;
    end else if (en) begin
      data_q <= {data_q[SIZE-2:0], serIn};
    end
  end

  assign serOut  = data_q[SIZE-1];
  assign dataOut = data_q;

endmodule

// File: rtl/shift_frame_ctrl.sv
// Full-duplex frame controller: loads a word, shifts SIZE bits MSB-first at a
// programmable bit period while sampling ser_in, then strobes the received word.
module shift_frame_ctrl
  import shift_frame_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             busy,
  shift_frame_ctrl_if.slave bus
);

  localparam int unsigned CW = cnt_width(SIZE);

  state_t          state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SIZE-1:0]  rx_data_q, rx_data_d;

  logic            load;
  logic            shift_en;
  logic            sr_ser;
  logic [SIZE-1:0] sr_data;

  assign load = bus.tx_valid && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = rx_data_q;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          div_d     = div;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (div_cnt_q == div_q) begin
          shift_en  = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          // Final bit: the register has not shifted yet, so splice ser_in in here.
          if (bit_cnt_q == CW'(SIZE - 1)) begin
            rx_data_d = {sr_data[SIZE-2:0], ser_in};
            bit_cnt_d = '0;
            state_d   = DONE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
    end
  end

  shift_register #(
    .SIZE(SIZE)
  ) u_shift_register (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (shift_en),
    .serIn  (ser_in),
    .dataIn (bus.tx_data),
    .serOut (sr_ser),
    .dataOut(sr_data)
  );

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.rx_valid = (state_q == DONE);
  assign bus.rx_data  = rx_data_q;
  assign busy         = (state_q != IDLE);
  assign ser_out      = (state_q == SHIFT) && sr_ser;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Self-checking bench for shift_frame_ctrl: table vectors, corner sequences and
// randomized frames against a cycle-numbered reference of the frame timing.
module tb_shift_frame_ctrl;

  localparam int SIZE  = 8;
  localparam int DIV_W = 8;

  localparam int M_LOOP  = 0;
  localparam int M_ZEROS = 1;
  localparam int M_ONES  = 2;
  localparam int M_RAND  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIV_W-1:0] div;
  logic             abort;
  logic             ser_in;
  logic             ser_out;
  logic             busy;

  shift_frame_ctrl_if #(.SIZE(SIZE)) bus ();

  shift_frame_ctrl #(
    .SIZE (SIZE),
    .DIV_W(DIV_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div    (div),
    .abort  (abort),
    .ser_in (ser_in),
    .ser_out(ser_out),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [SIZE-1:0] tx;
    int              d;
    int              mode;
    logic [SIZE-1:0] exp_rx;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ser(input int mode);
    case (mode)
      M_LOOP:  ser_in = ser_out;
      M_ZEROS: ser_in = 1'b0;
      M_ONES:  ser_in = 1'b1;
      default: ser_in = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic idle_check(input int n, input logic [SIZE-1:0] exp_rx);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx_ready", bus.tx_ready, 1);
      check("idle_busy",     busy,         0);
      check("idle_ser_out",  ser_out,      0);
      check("idle_rx_valid", bus.rx_valid, 0);
      check("idle_rx_data",  bus.rx_data,  exp_rx);
    end
  endtask

  // Cycle 0 is the acceptance cycle; bit k is driven in cycles 1+kP..(k+1)P and
  // ser_in is sampled in cycle (k+1)P; rx_valid lands in cycle SIZE*P+1.
  // mid_div: -1 leave div alone, -2 scramble every cycle, >=0 write it in cycle 5.
  task automatic run_frame(input logic [SIZE-1:0] tx, input int d, input int mode,
                           input logic [SIZE-1:0] exp_rx, input bit use_model,
                           input bit hold_valid, input int mid_div, input bit abort_c0,
                           output logic [SIZE-1:0] got_rx);
    int P;
    int k;
    logic [SIZE-1:0] model_rx;
    P        = d + 1;
    model_rx = '0;
    @(negedge clk);
    check("c0_tx_ready", bus.tx_ready, 1);
    check("c0_busy",     busy,         0);
    bus.tx_valid = 1'b1;
    bus.tx_data  = tx;
    div          = DIV_W'(d);
    abort        = abort_c0;
    drive_ser(mode);
    for (int c = 1; c <= SIZE * P + 1; c++) begin
      @(negedge clk);
      if (!hold_valid) bus.tx_valid = 1'b0;
      abort = 1'b0;
      if (mid_div == -2) div = DIV_W'($urandom);
      else if (mid_div >= 0 && c == 5) div = DIV_W'(mid_div);
      check("frame_tx_ready", bus.tx_ready, 0);
      check("frame_busy",     busy,         1);
      if (c <= SIZE * P) begin
        k = (c - 1) / P;
        check("ser_out_bit", ser_out, tx[SIZE-1-k]);
        check("rx_valid_early", bus.rx_valid, 0);
        drive_ser(mode);
        if (c % P == 0) model_rx = {model_rx[SIZE-2:0], ser_in};
      end else begin
        check("done_ser_out",  ser_out,      0);
        check("done_rx_valid", bus.rx_valid, 1);
        check("done_rx_data",  bus.rx_data,  use_model ? model_rx : exp_rx);
      end
    end
    got_rx = use_model ? model_rx : exp_rx;
  endtask

  initial begin
    logic [SIZE-1:0] last_rx;
    logic [SIZE-1:0] rtx;
    int              rd;

    rst_n        = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    div          = '0;
    abort        = 1'b0;
    ser_in       = 1'b0;

    tbl[0] = '{8'hA5, 0, M_LOOP,  8'hA5};
    tbl[1] = '{8'h00, 3, M_ONES,  8'hFF};
    tbl[2] = '{8'hFF, 2, M_ZEROS, 8'h00};
    tbl[3] = '{8'h81, 1, M_LOOP,  8'h81};
    tbl[4] = '{8'h0F, 4, M_ONES,  8'hFF};
    tbl[5] = '{8'h5A, 0, M_LOOP,  8'h5A};

    #12;
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_busy",     busy,         0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_ser_out",  ser_out,      0);
    check("rst_rx_data",  bus.rx_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(2, '0);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].tx, tbl[i].d, tbl[i].mode, tbl[i].exp_rx, 1'b0, 1'b0, -1, 1'b0, last_rx);
      idle_check(1, tbl[i].exp_rx);
    end

    // Abort in cycle 4 of a div=0 frame, previous word 0x5A.
    @(negedge clk);
    check("ab_c0_tx_ready", bus.tx_ready, 1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    div          = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.tx_valid = 1'b0;
      check("ab_busy",    busy,    1);
      check("ab_ser_out", ser_out, 1);
      if (c == 4) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    check("ab_tx_ready", bus.tx_ready, 1);
    check("ab_busy_off", busy,         0);
    check("ab_ser_out0", ser_out,      0);
    check("ab_rx_valid", bus.rx_valid, 0);
    check("ab_rx_data",  bus.rx_data,  8'h5A);
    idle_check(3, 8'h5A);

    // Back-to-back with tx_valid held high: second word accepted in cycle 10.
    run_frame(8'h3C, 0, M_LOOP, 8'h3C, 1'b0, 1'b1, -1, 1'b0, last_rx);
    run_frame(8'hC3, 0, M_LOOP, 8'hC3, 1'b0, 1'b0, -1, 1'b0, last_rx);
    idle_check(2, 8'hC3);

    // div changes 1 -> 7 in cycle 5; the frame keeps its 2-cycle bit period.
    run_frame(8'h96, 1, M_LOOP, 8'h96, 1'b0, 1'b0, 7, 1'b0, last_rx);
    idle_check(1, 8'h96);

    // abort raised together with acceptance in IDLE is ignored.
    run_frame(8'h69, 0, M_LOOP, 8'h69, 1'b0, 1'b0, -1, 1'b1, last_rx);
    idle_check(1, 8'h69);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hE7;
    div          = 8'd2;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy",    busy,    1);
    check("pre_rst_ser_out", ser_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx_ready", bus.tx_ready, 1);
    check("arst_busy",     busy,         0);
    check("arst_rx_valid", bus.rx_valid, 0);
    check("arst_ser_out",  ser_out,      0);
    check("arst_rx_data",  bus.rx_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(1, '0);
    run_frame(8'h3E, 1, M_LOOP, 8'h3E, 1'b0, 1'b0, -1, 1'b0, last_rx);
    idle_check(1, 8'h3E);

    for (int i = 0; i < 24; i++) begin
      rtx = SIZE'($urandom);
      rd  = int'($urandom_range(0, 3));
      if (i % 2 == 0)
        run_frame(rtx, rd, M_LOOP, rtx, 1'b0, 1'b0, -2, 1'b0, last_rx);
      else
        run_frame(rtx, rd, M_RAND, '0, 1'b1, 1'b0, -2, 1'b0, last_rx);
      idle_check(int'($urandom_range(1, 2)), last_rx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
